// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back buffer in front of the register file
// write port (A3/WD3/WE3). Requests arrive on a valid/ready handshake. They
// are held in a DEPTH-entry FIFO and drained one per cycle when drain_en allows.
// Build option: define WB_QUEUE_BYPASS_EN to add the decode bypass lookup.
// Without it, byp_hit1/2 and byp_d1/2 are tied to 0 and the ports stay present.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     drain_en,
    output logic                     we3,
    output logic [4:0]               a3,
    output logic [XLEN-1:0]          wd3,
    input  logic [4:0]               byp_a1,
    input  logic [4:0]               byp_a2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [XLEN-1:0]          byp_d1,
    output logic [XLEN-1:0]          byp_d2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic push;
    logic pop;

    // Handshake, drain port and next-state pointer/occupancy logic.
    // in_ready is gated by rst so it reads 0 while reset is held.
    // An in_rd of 0 completes the handshake, but nothing is stored for it.
    always_comb begin
        in_ready = rst && (count_q < CNT_W'(DEPTH));
        push     = in_valid && in_ready && (in_rd != 5'd0);
        pop      = drain_en && (count_q != '0);
        we3      = pop;
        a3       = (count_q != '0) ? rd_q[head_q]   : 5'd0;
        wd3      = (count_q != '0) ? data_q[head_q] : '0;

        head_d   = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push ? tail_q + PTR_W'(1) : tail_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head is never the tail slot when a push and a pop both happen:
        // a pop needs count > 0 and a push needs count < DEPTH.
        valid_d = valid_q;
        if (pop)  valid_d[head_q] = 1'b0;
        if (push) valid_d[tail_q] = 1'b1;
    end

    assign count = count_q;

    // Control state; an asynchronous reset drops every pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage. It has no reset, because valid_q and count_q
    // decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    // Youngest-match lookup: walk from head (oldest) to tail so that later
    // matches override earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        byp_hit1 = 1'b0;
        byp_hit2 = 1'b0;
        byp_d1   = '0;
        byp_d2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (byp_a1 != 5'd0) && (rd_q[idx] == byp_a1)) begin
                byp_hit1 = 1'b1;
                byp_d1   = data_q[idx];
            end
            if (valid_q[idx] && (byp_a2 != 5'd0) && (rd_q[idx] == byp_a2)) begin
                byp_hit2 = 1'b1;
                byp_d2   = data_q[idx];
            end
        end
    end
`else
    logic byp_unused;

    // The bypass is not built, so its outputs are held at 0.
    always_comb begin
        byp_unused = ^{byp_a1, byp_a2};
        byp_hit1   = 1'b0;
        byp_hit2   = 1'b0;
        byp_d1     = '0;
        byp_d2     = '0;
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue. A negedge monitor keeps a scoreboard
// of accepted writes and compares it with the drain port, occupancy and bypass.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic            drain_en;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic [4:0]      byp_a1;
    logic [4:0]      byp_a2;
    logic            byp_hit1;
    logic            byp_hit2;
    logic [XLEN-1:0] byp_d1;
    logic [XLEN-1:0] byp_d2;
    logic [2:0]      count;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en), .we3(we3), .a3(a3), .wd3(wd3),
        .byp_a1(byp_a1), .byp_a2(byp_a2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_d1(byp_d1), .byp_d2(byp_d2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void byp_model(input logic [4:0] a, output logic hit,
                                      output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_QUEUE_BYPASS_EN
        if (a != 5'd0) begin
            foreach (sb[i]) begin
                if (sb[i].rd == a) begin
                    hit = 1'b1;
                    d   = sb[i].data;
                end
            end
        end
`endif
    endfunction

    // The scoreboard drops all pending writes when reset is asserted.
    always @(negedge rst) sb.delete();

    // Monitor. It checks the state seen this cycle and pops a drained head.
    // Then it pushes any request that the coming edge will accept.
    always @(negedge clk) begin
        logic            h;
        logic [XLEN-1:0] d;
        if (rst) begin
            check("mon_count", 64'(count), 64'(sb.size()));
            check("mon_in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
            check("mon_we3", 64'(we3), 64'(drain_en && (sb.size() != 0)));
            byp_model(byp_a1, h, d);
            check("mon_hit1", 64'(byp_hit1), 64'(h));
            check("mon_d1", 64'(byp_d1), 64'(d));
            byp_model(byp_a2, h, d);
            check("mon_hit2", 64'(byp_hit2), 64'(h));
            check("mon_d2", 64'(byp_d2), 64'(d));
            if (we3) begin
                if (sb.size() == 0) begin
                    check("unexpected_we3", 64'(we3), 64'(0));
                end else begin
                    check("drain_a3", 64'(a3), 64'(sb[0].rd));
                    check("drain_wd3", 64'(wd3), 64'(sb[0].data));
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready && (in_rd != 5'd0))
                sb.push_back('{rd: in_rd, data: in_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] rd, input logic [XLEN-1:0] data);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        cyc();
        in_valid = 1'b0;
    endtask

    localparam bit BYP = `ifdef WB_QUEUE_BYPASS_EN 1'b1 `else 1'b0 `endif;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        drain_en = 1'b0; byp_a1 = 5'd5; byp_a2 = 5'd9;
        #2;
        check("rst_we3", 64'(we3), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_hit1", 64'(byp_hit1), 64'(0));
        check("rst_a3", 64'(a3), 64'(0));
        check("rst_wd3", 64'(wd3), 64'(0));
        cyc(); cyc();
        rst = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'(1));

        // 1: single write with drain enabled, one-cycle latency
        drain_en = 1'b1;
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h25;
        check("t1_no_same_cycle_we3", 64'(we3), 64'(0));
        cyc();
        in_valid = 1'b0;
        check("t1_we3", 64'(we3), 64'(1));
        check("t1_a3", 64'(a3), 64'(5));
        check("t1_wd3", 64'(wd3), 64'(32'h25));
        cyc();
        check("t1_count_after", 64'(count), 64'(0));

        // 2: fill, stall, drain in order
        drain_en = 1'b0;
        enq(5'd9, 32'h20); enq(5'd6, 32'h40); enq(5'd11, 32'h28); enq(5'd12, 32'h30);
        check("t2_full_count", 64'(count), 64'(4));
        check("t2_full_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1; in_rd = 5'd13; in_data = 32'h55;
        drain_en = 1'b1;
        check("t2_full_drain_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        check("t2_head_a3", 64'(a3), 64'(9));
        cyc();
        check("t2_ready_after_drain", 64'(in_ready), 64'(1));
        check("t2_count_3", 64'(count), 64'(3));
        check("t2_next_a3", 64'(a3), 64'(6));
        cyc(); cyc(); cyc();
        check("t2_empty", 64'(count), 64'(0));

        // 3: duplicate rd, youngest data wins in bypass
        drain_en = 1'b0;
        enq(5'd7, 32'h11); enq(5'd7, 32'h22);
        byp_a1 = 5'd7; byp_a2 = 5'd0;
        #1;
        check("t3_hit1", 64'(byp_hit1), 64'(BYP));
        check("t3_d1", 64'(byp_d1), BYP ? 64'h22 : 64'h0);
        check("t3_hit2", 64'(byp_hit2), 64'(0));
        check("t3_d2", 64'(byp_d2), 64'(0));
        drain_en = 1'b1;
        cyc(); cyc();
        check("t3_drained", 64'(count), 64'(0));

        // 4: rd=0 completes handshake but is never stored
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF_FFFF; byp_a1 = 5'd0;
        #1;
        check("t4_ready", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        check("t4_count", 64'(count), 64'(0));
        check("t4_we3", 64'(we3), 64'(0));
        check("t4_hit1", 64'(byp_hit1), 64'(0));
        cyc();

        // 5: steady state with 3 entries, pointers wrap
        drain_en = 1'b0;
        byp_a1 = 5'd2; byp_a2 = 5'd3;
        enq(5'd1, 32'h101); enq(5'd2, 32'h102); enq(5'd3, 32'h103);
        drain_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_rd    = 5'(4 + k);
            in_data  = $urandom;
            cyc();
            check("t5_count_steady", 64'(count), 64'(3));
        end
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        check("t5_drained", 64'(count), 64'(0));

        // 6: asynchronous reset mid-cycle discards pending writes
        drain_en = 1'b0;
        enq(5'd14, 32'hAA); enq(5'd15, 32'hBB);
        byp_a1 = 5'd14;
        drain_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("t6_we3", 64'(we3), 64'(0));
        check("t6_count", 64'(count), 64'(0));
        check("t6_hit1", 64'(byp_hit1), 64'(0));
        check("t6_ready", 64'(in_ready), 64'(0));
        cyc(); cyc();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t6_no_stale_we3", 64'(we3), 64'(0));
        end

        check("sb_empty_at_end", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
